rv_icache_stage: RTL and testbench

Instruction-fetch stage directly downstream of the warp scheduler. It accepts per-warp fetch requests (wid, PC, tmask, uuid), issues word-aligned reads to the instruction cache, and keeps per-warp metadata while the read is in flight. It re-associates each cache response with its warp and drives a registered fetch response toward decode. It enforces at most one outstanding fetch per warp and reports busy for core drain.

---
 rtl/rv_icache_stage.sv | 141 ++++++++++++++
 tb/tb_rv_icache_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_icache_stage.sv
// rv_icache_stage: per-warp ifetch -> icache request/response re-association with a single-entry output register.
// Optional perf counters are built only when ICACHE_STAGE_PERF_EN is defined.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_BITS
`define UUID_BITS 8
`endif

module rv_icache_stage #(
  parameter int ADDR_WIDTH = 30,
  parameter int TAG_WIDTH  = `UUID_BITS + `NW_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ifetch_req_valid,
  output logic                    ifetch_req_ready,
  input  logic [`UUID_BITS-1:0]   ifetch_req_uuid,
  input  logic [`NUM_THREADS-1:0] ifetch_req_tmask,
  input  logic [`NW_BITS-1:0]     ifetch_req_wid,
  input  logic [31:0]             ifetch_req_PC,
  output logic                    icache_req_valid,
  input  logic                    icache_req_ready,
  output logic [ADDR_WIDTH-1:0]   icache_req_addr,
  output logic [TAG_WIDTH-1:0]    icache_req_tag,
  input  logic                    icache_rsp_valid,
  output logic                    icache_rsp_ready,
  input  logic [31:0]             icache_rsp_data,
  input  logic [TAG_WIDTH-1:0]    icache_rsp_tag,
  output logic                    ifetch_rsp_valid,
  input  logic                    ifetch_rsp_ready,
  output logic [`UUID_BITS-1:0]   ifetch_rsp_uuid,
  output logic [`NUM_THREADS-1:0] ifetch_rsp_tmask,
  output logic [`NW_BITS-1:0]     ifetch_rsp_wid,
  output logic [31:0]             ifetch_rsp_PC,
  output logic [31:0]             ifetch_rsp_instr,
  output logic                    tag_err,
  output logic                    busy
`ifdef ICACHE_STAGE_PERF_EN
  ,
  output logic [43:0]             perf_icache_stalls,
  output logic [43:0]             perf_icache_pending
`endif
);
  localparam int NW = `NUM_WARPS;
  logic [NW-1:0]           pending_q, pending_d;
  logic [31:0]             meta_pc_q [NW];
  logic [`NUM_THREADS-1:0] meta_tmask_q [NW];
  logic                    out_valid_q, tag_err_q;
  logic [`UUID_BITS-1:0]   out_uuid_q;
  logic [`NUM_THREADS-1:0] out_tmask_q;
  logic [`NW_BITS-1:0]     out_wid_q;
  logic [31:0]             out_pc_q, out_instr_q;
  logic                    req_fire, rsp_fire;
  logic [`NW_BITS-1:0]     rsp_wid;
  logic [`UUID_BITS-1:0]   rsp_uuid;

  assign icache_req_valid = ifetch_req_valid & ~pending_q[ifetch_req_wid];
  assign ifetch_req_ready = icache_req_ready & ~pending_q[ifetch_req_wid];
  assign icache_req_addr  = ifetch_req_PC[31:2];
  assign icache_req_tag   = {ifetch_req_uuid, ifetch_req_wid};
  assign req_fire         = icache_req_valid & icache_req_ready;
  assign rsp_wid          = icache_rsp_tag[`NW_BITS-1:0];
  assign rsp_uuid         = icache_rsp_tag[TAG_WIDTH-1:`NW_BITS];
  assign icache_rsp_ready = ~out_valid_q | ifetch_rsp_ready;
  assign rsp_fire         = icache_rsp_valid & icache_rsp_ready;

  // Clear before set so a same-warp request landing with a stray response stays pending.
  always_comb begin
    pending_d = pending_q;
    if (rsp_fire) pending_d[rsp_wid] = 1'b0;
    if (req_fire) pending_d[ifetch_req_wid] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      meta_pc_q[ifetch_req_wid]    <= ifetch_req_PC;
      meta_tmask_q[ifetch_req_wid] <= ifetch_req_tmask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      tag_err_q   <= 1'b0;
      out_uuid_q  <= '0;
      out_tmask_q <= '0;
      out_wid_q   <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (rsp_fire) begin
        out_valid_q <= 1'b1;
        out_uuid_q  <= rsp_uuid;
        out_tmask_q <= meta_tmask_q[rsp_wid];
        out_wid_q   <= rsp_wid;
        out_pc_q    <= meta_pc_q[rsp_wid];
        out_instr_q <= icache_rsp_data;
        if (!pending_q[rsp_wid]) tag_err_q <= 1'b1;
      end else if (ifetch_rsp_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign ifetch_rsp_valid = out_valid_q;
  assign ifetch_rsp_uuid  = out_uuid_q;
  assign ifetch_rsp_tmask = out_tmask_q;
  assign ifetch_rsp_wid   = out_wid_q;
  assign ifetch_rsp_PC    = out_pc_q;
  assign ifetch_rsp_instr = out_instr_q;
  assign tag_err          = tag_err_q;
  assign busy             = (|pending_q) | out_valid_q;

`ifdef ICACHE_STAGE_PERF_EN
  logic [43:0] stalls_q, pend_acc_q, pend_cnt;
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < NW; i++) pend_cnt = pend_cnt + 44'(pending_q[i]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stalls_q   <= '0;
      pend_acc_q <= '0;
    end else begin
      stalls_q   <= stalls_q + 44'(icache_req_valid & ~icache_req_ready);
      pend_acc_q <= pend_acc_q + pend_cnt;
    end
  end
  assign perf_icache_stalls  = stalls_q;
  assign perf_icache_pending = pend_acc_q;
`endif
endmodule

// File: tb/tb_rv_icache_stage.sv
// tb_rv_icache_stage: directed stimulus with a response scoreboard for rv_icache_stage.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_BITS
`define UUID_BITS 8
`endif

module tb_rv_icache_stage;
  logic clk = 0, reset = 1;
  logic ifetch_req_valid = 0, ifetch_req_ready;
  logic [7:0] ifetch_req_uuid = 0;
  logic [3:0] ifetch_req_tmask = 0;
  logic [1:0] ifetch_req_wid = 0;
  logic [31:0] ifetch_req_PC = 0;
  logic icache_req_valid, icache_req_ready = 1;
  logic [29:0] icache_req_addr;
  logic [9:0] icache_req_tag;
  logic icache_rsp_valid = 0, icache_rsp_ready;
  logic [31:0] icache_rsp_data = 0;
  logic [9:0] icache_rsp_tag = 0;
  logic ifetch_rsp_valid, ifetch_rsp_ready = 1;
  logic [7:0] ifetch_rsp_uuid;
  logic [3:0] ifetch_rsp_tmask;
  logic [1:0] ifetch_rsp_wid;
  logic [31:0] ifetch_rsp_PC, ifetch_rsp_instr;
  logic tag_err, busy;
`ifdef ICACHE_STAGE_PERF_EN
  logic [43:0] perf_icache_stalls, perf_icache_pending;
`endif

  int checks = 0, errors = 0;
  logic [77:0] exp_q [$];

  rv_icache_stage dut (
    .clk(clk), .reset(reset),
    .ifetch_req_valid(ifetch_req_valid), .ifetch_req_ready(ifetch_req_ready),
    .ifetch_req_uuid(ifetch_req_uuid), .ifetch_req_tmask(ifetch_req_tmask),
    .ifetch_req_wid(ifetch_req_wid), .ifetch_req_PC(ifetch_req_PC),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
    .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
    .ifetch_rsp_valid(ifetch_rsp_valid), .ifetch_rsp_ready(ifetch_rsp_ready),
    .ifetch_rsp_uuid(ifetch_rsp_uuid), .ifetch_rsp_tmask(ifetch_rsp_tmask),
    .ifetch_rsp_wid(ifetch_rsp_wid), .ifetch_rsp_PC(ifetch_rsp_PC),
    .ifetch_rsp_instr(ifetch_rsp_instr), .tag_err(tag_err), .busy(busy)
`ifdef ICACHE_STAGE_PERF_EN
    , .perf_icache_stalls(perf_icache_stalls), .perf_icache_pending(perf_icache_pending)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake is matched against the oldest expected response.
  always @(negedge clk) begin
    if (!reset && ifetch_rsp_valid && ifetch_rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got wid %0d PC %0h with empty scoreboard", ifetch_rsp_wid, ifetch_rsp_PC);
      end else begin
        logic [77:0] e, a;
        e = exp_q.pop_front();
        a = {ifetch_rsp_uuid, ifetch_rsp_tmask, ifetch_rsp_wid, ifetch_rsp_PC, ifetch_rsp_instr};
        if (a !== e) begin
          errors++;
          $display("FAIL rsp_payload: got %h expected %h", a, e);
        end
      end
    end
  end

  task automatic req(input logic [1:0] w, input logic [31:0] pc, input logic [3:0] tm, input logic [7:0] u);
    ifetch_req_valid = 1; ifetch_req_wid = w; ifetch_req_PC = pc; ifetch_req_tmask = tm; ifetch_req_uuid = u;
    #1;
    check("req_ready", 64'(ifetch_req_ready), 1);
    check("req_addr", 64'(icache_req_addr), 64'(pc >> 2));
    check("req_tag", 64'(icache_req_tag), 64'({u, w}));
    tick();
    ifetch_req_valid = 0;
  endtask

  task automatic rsp(input logic [7:0] u, input logic [1:0] w, input logic [31:0] d,
                     input logic [3:0] tm, input logic [31:0] pc);
    int n = 0;
    icache_rsp_valid = 1; icache_rsp_tag = {u, w}; icache_rsp_data = d;
    #1;
    while (!icache_rsp_ready && n < 20) begin tick(); n++; end
    if (!icache_rsp_ready) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: icache_rsp_ready 0 expected 1");
    end else exp_q.push_back({u, tm, w, pc, d});
    tick();
    icache_rsp_valid = 0;
    check("rsp_valid_next", 64'(ifetch_rsp_valid), 1);
  endtask

  task automatic probe(input string name, input logic [1:0] w, input logic exp);
    ifetch_req_valid = 0; ifetch_req_wid = w;
    #1;
    check(name, 64'(ifetch_req_ready), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    reset = 0;
    check("rst_valid", 64'(ifetch_rsp_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_tag_err", 64'(tag_err), 0);
    check("rst_payload", 64'({ifetch_rsp_uuid, ifetch_rsp_PC, ifetch_rsp_instr} != 0), 0);
    check("rst_rsp_ready", 64'(icache_rsp_ready), 1);

    // Single fetch
    req(0, 32'h8000_0000, 4'h1, 8'd5);
    check("busy_pending", 64'(busy), 1);
    rsp(8'd5, 0, 32'h13, 4'h1, 32'h8000_0000);
    tick();
    check("busy_drained", 64'(busy), 0);

    // Per-warp blocking; warp 2 still accepted
    req(1, 32'h100, 4'h3, 8'd7);
    ifetch_req_valid = 1; ifetch_req_wid = 1; ifetch_req_PC = 32'h104; ifetch_req_tmask = 4'hF; ifetch_req_uuid = 9;
    #1;
    check("blk_ready", 64'(ifetch_req_ready), 0);
    check("blk_ic_valid", 64'(icache_req_valid), 0);
    tick();
    check("blk_ready2", 64'(ifetch_req_ready), 0);
    req(2, 32'h200, 4'h5, 8'd8);
    ifetch_req_valid = 1; ifetch_req_wid = 1; ifetch_req_PC = 32'h104; ifetch_req_tmask = 4'hF; ifetch_req_uuid = 9;
    icache_rsp_valid = 1; icache_rsp_tag = {8'd7, 2'd1}; icache_rsp_data = 32'hAAAA;
    #1;
    check("same_cyc_ready", 64'(ifetch_req_ready), 0);
    check("same_cyc_rsp_rdy", 64'(icache_rsp_ready), 1);
    exp_q.push_back({8'd7, 4'h3, 2'd1, 32'h100, 32'hAAAA});
    tick();
    icache_rsp_valid = 0;
    #1;
    check("unblk_ready", 64'(ifetch_req_ready), 1);
    check("unblk_addr", 64'(icache_req_addr), 64'h41);
    tick();
    ifetch_req_valid = 0;
    rsp(8'd9, 1, 32'hBBBB, 4'hF, 32'h104);
    rsp(8'd8, 2, 32'hCCCC, 4'h5, 32'h200);

    // Out-of-order returns
    req(0, 32'h400, 4'h1, 8'd10);
    req(3, 32'h800, 4'h8, 8'd11);
    rsp(8'd11, 3, 32'h3333, 4'h8, 32'h800);
    probe("ooo_w3_clear", 3, 1);
    probe("ooo_w0_pend", 0, 0);
    rsp(8'd10, 0, 32'h4444, 4'h1, 32'h400);
    probe("ooo_w0_clear", 0, 1);

    // Backpressure
    req(0, 32'h1000, 4'h2, 8'd20);
    req(1, 32'h2000, 4'h4, 8'd21);
    ifetch_rsp_ready = 0;
    rsp(8'd20, 0, 32'h5555, 4'h2, 32'h1000);
    icache_rsp_valid = 1; icache_rsp_tag = {8'd21, 2'd1}; icache_rsp_data = 32'h6666;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp_ready", 64'(icache_rsp_ready), 0);
      check("bp_hold", 64'({ifetch_rsp_valid, ifetch_rsp_PC, ifetch_rsp_instr}), 64'({1'b1, 32'h1000, 32'h5555}));
      tick();
    end
    ifetch_rsp_ready = 1;
    #1;
    check("bp_release_rdy", 64'(icache_rsp_ready), 1);
    exp_q.push_back({8'd21, 4'h4, 2'd1, 32'h2000, 32'h6666});
    tick();
    icache_rsp_valid = 0;
    check("bp_second", 64'({ifetch_rsp_valid, ifetch_rsp_instr}), 64'({1'b1, 32'h6666}));
    tick();

    // Stray response: warp 2 not pending, meta[2] still {0x200, 5}
    check("pre_tag_err", 64'(tag_err), 0);
    rsp(8'd3, 2, 32'h7777, 4'h5, 32'h200);
    check("tag_err_set", 64'(tag_err), 1);
    tick(); tick(); tick();
    check("tag_err_sticky", 64'(tag_err), 1);

    // Reset with three warps pending
    req(0, 32'h10, 4'h1, 8'd30);
    req(1, 32'h14, 4'h2, 8'd31);
    req(3, 32'h18, 4'h4, 8'd32);
    check("busy_3pend", 64'(busy), 1);
    reset = 1;
    tick();
    reset = 0;
    check("rst2_busy", 64'(busy), 0);
    check("rst2_tag_err", 64'(tag_err), 0);
    check("rst2_valid", 64'(ifetch_rsp_valid), 0);
    probe("rst2_w0", 0, 1);
    probe("rst2_w1", 1, 1);
    probe("rst2_w3", 3, 1);
    rsp(8'd33, 1, 32'h8888, 4'h2, 32'h14);
    check("late_tag_err", 64'(tag_err), 1);
    tick(); tick();
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
